// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control : control unit for a multicycle MIPS-subset datapath.
//
// A five-state FSM (IF, ID, EXE, MEM, WB) decodes op/func and drives the
// datapath selects and write enables for each cycle of an instruction.
//
// Ports
//   clock     in   single clock, rising edge
//   resetn    in   asynchronous active-low reset
//   op        in   instruction[31:26], held by the instruction register
//   func      in   instruction[5:0]
//   z         in   ALU zero flag (combinational, same cycle)
//   aluc      out  ALU operation code
//   alu_srca  out  ALU A select: 00 pc, 01 rs, 10 shamt
//   alu_srcb  out  ALU B select: 00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2
//   pcsource  out  next-PC select: 00 ALU, 01 branch target, 10 rs, 11 jump
//   pc_en     out  PC write enable
//   ir_load   out  instruction register load
//   wreg      out  register file write enable
//   wmem      out  data memory write enable
//   regrt     out  destination register is rt
//   m2reg     out  register write data comes from memory
//   sext      out  sign-extend the immediate
//   jal       out  destination $31, write data = pc
//   state     out  current FSM state (debug)
// ---------------------------------------------------------------------------
module mc_control (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic [3:0] aluc,
  output logic [1:0] alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] pcsource,
  output logic       pc_en,
  output logic       ir_load,
  output logic       wreg,
  output logic       wmem,
  output logic       regrt,
  output logic       m2reg,
  output logic       sext,
  output logic       jal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_t state_q, state_d;

  // Instruction decode
  logic is_r;
  logic r_add, r_sub, r_and, r_or, r_xor, r_sll, r_srl, r_sra, r_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic is_shift, r_alu, i_alu, is_mem, is_br, supported;

  assign is_r   = (op == 6'b000000);
  assign r_add  = is_r && (func == 6'b100000);
  assign r_sub  = is_r && (func == 6'b100010);
  assign r_and  = is_r && (func == 6'b100100);
  assign r_or   = is_r && (func == 6'b100101);
  assign r_xor  = is_r && (func == 6'b100110);
  assign r_sll  = is_r && (func == 6'b000000);
  assign r_srl  = is_r && (func == 6'b000010);
  assign r_sra  = is_r && (func == 6'b000011);
  assign r_jr   = is_r && (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_lui  = (op == 6'b001111);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign is_shift  = r_sll || r_srl || r_sra;
  assign r_alu     = r_add || r_sub || r_and || r_or || r_xor || is_shift;
  assign i_alu     = i_addi || i_andi || i_ori || i_xori || i_lui;
  assign is_mem    = i_lw || i_sw;
  assign is_br     = i_beq || i_bne;
  assign supported = r_alu || r_jr || i_alu || is_mem || is_br || i_j || i_jal;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IF;
    else         state_q <= state_d;
  end

  // Raw enables before the reset gate
  logic pc_en_c, ir_load_c, wreg_c, wmem_c;

  // Next state and outputs
  always_comb begin
    state_d   = S_IF;
    aluc      = ALU_ADD;
    alu_srca  = 2'b00;
    alu_srcb  = 2'b00;
    pcsource  = 2'b00;
    pc_en_c   = 1'b0;
    ir_load_c = 1'b0;
    wreg_c    = 1'b0;
    wmem_c    = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    jal       = 1'b0;
    sext      = i_addi || i_lw || i_sw || i_beq || i_bne;

    case (state_q)
      S_IF: begin
        ir_load_c = 1'b1;
        pc_en_c   = 1'b1;
        alu_srcb  = 2'b01;
        state_d   = S_ID;
      end

      S_ID: begin
        // Branch target pc + (sext imm << 2) is computed here and held outside.
        alu_srcb = 2'b11;
        if (i_j) begin
          pc_en_c  = 1'b1;
          pcsource = 2'b11;
          state_d  = S_IF;
        end else if (r_jr) begin
          pc_en_c  = 1'b1;
          pcsource = 2'b10;
          state_d  = S_IF;
        end else if (i_jal) begin
          state_d  = S_WB;
        end else if (!supported) begin
          state_d  = S_IF;
        end else begin
          state_d  = S_EXE;
        end
      end

      S_EXE: begin
        if (r_alu) begin
          alu_srca = is_shift ? 2'b10 : 2'b01;
          alu_srcb = 2'b00;
        end else if (i_alu || is_mem) begin
          alu_srca = 2'b01;
          alu_srcb = 2'b10;
        end else if (is_br) begin
          // rs - rt feeds the zero flag used for the branch decision
          alu_srca = 2'b01;
          alu_srcb = 2'b00;
          pcsource = 2'b01;
          pc_en_c  = (i_beq && z) || (i_bne && !z);
        end

        if (r_add || i_addi || is_mem)  aluc = ALU_ADD;
        else if (r_sub || is_br)        aluc = ALU_SUB;
        else if (r_and || i_andi)       aluc = ALU_AND;
        else if (r_or  || i_ori)        aluc = ALU_OR;
        else if (r_xor || i_xori)       aluc = ALU_XOR;
        else if (i_lui)                 aluc = ALU_LUI;
        else if (r_sll)                 aluc = ALU_SLL;
        else if (r_srl)                 aluc = ALU_SRL;
        else if (r_sra)                 aluc = ALU_SRA;

        if (is_br)       state_d = S_IF;
        else if (is_mem) state_d = S_MEM;
        else             state_d = S_WB;
      end

      S_MEM: begin
        if (i_sw) begin
          wmem_c  = 1'b1;
          state_d = S_IF;
        end else if (i_lw) begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        wreg_c = 1'b1;
        regrt  = i_alu || i_lw;
        m2reg  = i_lw;
        if (i_jal) begin
          jal      = 1'b1;
          pc_en_c  = 1'b1;
          pcsource = 2'b11;
        end
      end

      default: state_d = S_IF;
    endcase
  end

  // Write enables are gated by reset so an aborted instruction cannot write.
  assign pc_en   = pc_en_c   && resetn;
  assign ir_load = ir_load_c && resetn;
  assign wreg    = wreg_c    && resetn;
  assign wmem    = wmem_c    && resetn;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control : self-checking bench for mc_control.
// Expected per-cycle output vectors are queued when an instruction is
// launched and popped/compared once per cycle on the falling edge.
// Vector layout: {state, aluc, srca, srcb, pcsource,
//                 pc_en, ir_load, wreg, wmem, regrt, m2reg, sext, jal}
// ---------------------------------------------------------------------------
module tb_mc_control;

  logic       clock;
  logic       resetn;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic [3:0] aluc;
  logic [1:0] alu_srca, alu_srcb, pcsource;
  logic       pc_en, ir_load, wreg, wmem, regrt, m2reg, sext, jal;
  logic [2:0] state;

  mc_control dut (
    .clock    (clock),
    .resetn   (resetn),
    .op       (op),
    .func     (func),
    .z        (z),
    .aluc     (aluc),
    .alu_srca (alu_srca),
    .alu_srcb (alu_srcb),
    .pcsource (pcsource),
    .pc_en    (pc_en),
    .ir_load  (ir_load),
    .wreg     (wreg),
    .wmem     (wmem),
    .regrt    (regrt),
    .m2reg    (m2reg),
    .sext     (sext),
    .jal      (jal),
    .state    (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [20:0] obs;
  assign obs = {state, aluc, alu_srca, alu_srcb, pcsource,
                pc_en, ir_load, wreg, wmem, regrt, m2reg, sext, jal};

  logic [20:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // flags: {pc_en, ir_load, wreg, wmem, regrt, m2reg, sext, jal}
  task automatic push(input logic [2:0] st, input logic [3:0] a, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [1:0] ps, input logic [7:0] fl);
    sb_q.push_back({st, a, sa, sb, ps, fl});
  endtask

  task automatic push_if(input logic s);
    push(3'd0, 4'b0000, 2'b00, 2'b01, 2'b00, {7'b1100000, 1'b0} | {6'b0, s, 1'b0});
  endtask

  task automatic push_id(input logic s);
    push(3'd1, 4'b0000, 2'b00, 2'b11, 2'b00, {6'b0, s, 1'b0});
  endtask

  // Drive an instruction (starting in IF, at a falling edge) and compare
  // one queued vector per cycle until the queue drains.
  task automatic run(input string name, input logic [5:0] o, input logic [5:0] f, input logic zz);
    int idx;
    op = o; func = f; z = zz;
    idx = 0;
    while (sb_q.size() > 0 && idx < 16) begin
      #1;
      check_eq($sformatf("%s_c%0d", name, idx), obs, sb_q.pop_front());
      @(negedge clock);
      idx++;
    end
    if (sb_q.size() != 0) begin
      check_eq({name, "_drain"}, 21'(sb_q.size()), 21'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    resetn = 1'b0; op = 6'b0; func = 6'b100000; z = 1'b0;
    #3;
    // Reset: IF values with enables forced low
    check_eq("reset", obs, {3'd0, 4'b0000, 2'b00, 2'b01, 2'b00, 8'b00000000});
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;

    // add
    push_if(0); push_id(0);
    push(3'd2, 4'b0000, 2'b01, 2'b00, 2'b00, 8'b00000000);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00100000);
    run("add", 6'b000000, 6'b100000, 1'b0);

    // sub
    push_if(0); push_id(0);
    push(3'd2, 4'b0100, 2'b01, 2'b00, 2'b00, 8'b00000000);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00100000);
    run("sub", 6'b000000, 6'b100010, 1'b0);

    // lw
    push_if(1); push_id(1);
    push(3'd2, 4'b0000, 2'b01, 2'b10, 2'b00, 8'b00000010);
    push(3'd3, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00000010);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00101110);
    run("lw", 6'b100011, 6'b000000, 1'b0);

    // sw
    push_if(1); push_id(1);
    push(3'd2, 4'b0000, 2'b01, 2'b10, 2'b00, 8'b00000010);
    push(3'd3, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00010010);
    run("sw", 6'b101011, 6'b000000, 1'b0);

    // beq taken / not taken
    push_if(1); push_id(1);
    push(3'd2, 4'b0100, 2'b01, 2'b00, 2'b01, 8'b10000010);
    run("beq_z1", 6'b000100, 6'b000000, 1'b1);
    push_if(1); push_id(1);
    push(3'd2, 4'b0100, 2'b01, 2'b00, 2'b01, 8'b00000010);
    run("beq_z0", 6'b000100, 6'b000000, 1'b0);

    // bne taken when z = 0
    push_if(1); push_id(1);
    push(3'd2, 4'b0100, 2'b01, 2'b00, 2'b01, 8'b10000010);
    run("bne_z0", 6'b000101, 6'b000000, 1'b0);

    // sra
    push_if(0); push_id(0);
    push(3'd2, 4'b1111, 2'b10, 2'b00, 2'b00, 8'b00000000);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00100000);
    run("sra", 6'b000000, 6'b000011, 1'b0);

    // ori
    push_if(0); push_id(0);
    push(3'd2, 4'b0101, 2'b01, 2'b10, 2'b00, 8'b00000000);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00101000);
    run("ori", 6'b001101, 6'b000000, 1'b0);

    // lui
    push_if(0); push_id(0);
    push(3'd2, 4'b0110, 2'b01, 2'b10, 2'b00, 8'b00000000);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00101000);
    run("lui", 6'b001111, 6'b000000, 1'b0);

    // j
    push_if(0);
    push(3'd1, 4'b0000, 2'b00, 2'b11, 2'b11, 8'b10000000);
    run("j", 6'b000010, 6'b000000, 1'b0);

    // jr
    push_if(0);
    push(3'd1, 4'b0000, 2'b00, 2'b11, 2'b10, 8'b10000000);
    run("jr", 6'b000000, 6'b001000, 1'b0);

    // jal
    push_if(0); push_id(0);
    push(3'd4, 4'b0000, 2'b00, 2'b00, 2'b11, 8'b10100001);
    run("jal", 6'b000011, 6'b000000, 1'b0);

    // unsupported opcode behaves as a nop
    push_if(0); push_id(0);
    push_if(0);
    run("nop", 6'b111111, 6'b000000, 1'b0);
    // that last IF entry advanced to ID; finish the cycle back to IF
    push_id(0);
    run("nop_tail", 6'b111111, 6'b000000, 1'b0);

    // Reset in the MEM cycle of sw
    push_if(1); push_id(1);
    push(3'd2, 4'b0000, 2'b01, 2'b10, 2'b00, 8'b00000010);
    run("swrst", 6'b101011, 6'b000000, 1'b0);
    #1;
    check_eq("swrst_mem", obs, {3'd3, 4'b0000, 2'b00, 2'b00, 2'b00, 8'b00010010});
    #2;
    resetn = 1'b0;
    #1;
    check_eq("swrst_abort", obs, {3'd0, 4'b0000, 2'b00, 2'b01, 2'b00, 8'b00000010});
    @(negedge clock);
    #1;
    check_eq("swrst_hold", obs, {3'd0, 4'b0000, 2'b00, 2'b01, 2'b00, 8'b00000010});
    resetn = 1'b1;
    #1;
    check_eq("swrst_if", obs, {3'd0, 4'b0000, 2'b00, 2'b01, 2'b00, 8'b11000010});
    @(negedge clock);
    #1;
    check_eq("swrst_id", obs, {3'd1, 4'b0000, 2'b00, 2'b11, 2'b00, 8'b00000010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have a port `clock`: input, 1 bit, single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have a port `resetn`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have a port `op`: input, 6 bits, instruction[31:26], held stable by the instruction register after IF.
REQ-004 The block SHALL have a port `func`: input, 6 bits, instruction[5:0].
REQ-005 The block SHALL have a port `z`: input, 1 bit, ALU zero flag, combinational, same cycle.
REQ-006 The block SHALL have a port `aluc`: output, 4 bits, ALU operation code.
REQ-007 The block SHALL have a port `alu_srca`: output, 2 bits, ALU A select: 00 = pc, 01 = reg rs, 10 = shamt.
REQ-008 The block SHALL have a port `alu_srcb`: output, 2 bits, ALU B select: 00 = reg rt, 01 = constant 4, 10 = ext imm, 11 = sext imm<<2.
REQ-009 The block SHALL have a port `pcsource`: output, 2 bits, next-PC select: 00 = ALU result, 01 = branch target register, 10 = rs, 11 = jump address.
REQ-010 The block SHALL have the following 1-bit outputs: `pc_en`, `ir_load`, `wreg`, `wmem`, `regrt` (dest = rt), `m2reg` (write data from memory), `sext` (sign-extend imm), `jal` (dest $31, data = pc).
REQ-011 The block SHALL have a port `state`: output, 3 bits, current state for debug.

Function
REQ-012 The block SHALL implement a registered FSM with states IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4; codes 5-7 SHALL transition to IF.
REQ-013 Supported instructions SHALL be: R-type (op 000000) add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000; I/J-type: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111, j 000010, jal 000011.
REQ-014 The `aluc` encoding SHALL be: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
REQ-015 In IF: `ir_load` = 1, `pc_en` = 1, `alu_srca` = 00, `alu_srcb` = 01, `aluc` = ADD, `pcsource` = 00; next state SHALL be ID.
REQ-016 In ID: `alu_srca` = 00, `alu_srcb` = 11, `aluc` = ADD (branch target latched externally); j: `pc_en` = 1, `pcsource` = 11, next state IF; jr: `pc_en` = 1, `pcsource` = 10, next state IF; jal: `pc_en` = 0, next state WB; unsupported encoding: next state IF (nop); all others: next state EXE.
REQ-017 In EXE: R-type ALU ops SHALL drive `alu_srca` = 01 (shifts: 10) and `alu_srcb` = 00; immediate ops, lw and sw SHALL drive `alu_srca` = 01 and `alu_srcb` = 10; `aluc` SHALL follow REQ-014; lw/sw SHALL use ADD; beq/bne SHALL use SUB.
REQ-018 Branch in EXE: `pc_en` = (beq & z) | (bne & ~z), `pcsource` = 01; next state IF.
REQ-019 EXE next state SHALL be MEM for lw/sw and WB otherwise.
REQ-020 In MEM: sw SHALL drive `wmem` = 1, next state IF; lw SHALL go to WB.
REQ-021 In WB: `wreg` = 1; `regrt` = 1 for I-type; `m2reg` = 1 for lw only; `jal` = 1 and `pc_en` = 1 with `pcsource` = 11 for jal; next state IF.
REQ-022 `sext` SHALL be 1 for addi, lw, sw, beq and bne, and 0 otherwise, in every state.
REQ-023 Outputs not listed for a state SHALL be 0; `wreg`, `wmem`, `pc_en` and `ir_load` SHALL never be asserted in any other state.
REQ-024 Latency in cycles SHALL be: j/jr 2, beq/bne 3, jal 3, R/I ALU ops 4, sw 4, lw 5.

Reset
REQ-025 While `resetn` = 0, `state` SHALL be IF and `pc_en`, `ir_load`, `wreg` and `wmem` SHALL be forced to 0 combinationally; other outputs SHALL take their IF values (`aluc` = 0000, `alu_srcb` = 01).
REQ-026 Reset asserted in any state SHALL abort the instruction with no further write enables; the first rising edge after release SHALL execute IF.

Verification
REQ-027 The bench SHALL cover add: op = 000000, func = 100000 -> states 0,1,2,4,0; EXE `aluc` = 0000 with srca/srcb = 01/00; WB `wreg` = 1, `regrt` = 0.
REQ-028 The bench SHALL cover lw: op = 100011 -> states 0,1,2,3,4; `sext` = 1; EXE srcb = 10; WB `m2reg` = 1, `regrt` = 1.
REQ-029 The bench SHALL cover beq: op = 000100 -> with z = 1, EXE `pc_en` = 1, `pcsource` = 01; with z = 0, `pc_en` = 0; next state 0 in both cases.
REQ-030 The bench SHALL cover sra: func = 000011 -> EXE `aluc` = 1111, `alu_srca` = 10; ori: op = 001101 -> `aluc` = 0101, `sext` = 0.
REQ-031 The bench SHALL cover j: op = 000010 -> ID `pc_en` = 1, `pcsource` = 11, 2-cycle instruction; jal -> WB `wreg` = 1, `jal` = 1.
REQ-032 The bench SHALL cover reset mid-instruction: sw in MEM, drive `resetn` low mid-cycle -> `wmem` falls to 0 immediately, `state` = 0; after release, IF asserts `ir_load` = 1.
